// File: rtl/fp_mac_pkg.sv
// Shared definitions for the FP partial-product alignment path:
// default widths, collector state encoding and partial-product field slices.
package fp_mac_pkg;

  localparam int EXP_W_DEF = 5;
  localparam int PP_W_DEF  = 5;

  // Partial product layout: sign on top, magnitude below it
  localparam int PP_SIGN   = PP_W_DEF - 1;
  localparam int PP_MAG_HI = PP_W_DEF - 2;
  localparam int PP_MAG_LO = 0;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/pp_group_buf.sv
// Group buffer: N x W register file, synchronous write,
// asynchronous read.
module pp_group_buf #(
  parameter int N     = 8,
  parameter int W     = 10,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/exp_max_collect.sv
// Collects a group of partial products, finds the max exponent over
// nonzero beats, then replays the group with that max attached.
module exp_max_collect
  import fp_mac_pkg::*;
#(
  parameter int N_PP  = 8,
  parameter int EXP_W = EXP_W_DEF,
  parameter int PP_W  = PP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [PP_W-1:0]  in_pp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_exp,
  output logic [EXP_W-1:0] out_exp_max,
  output logic [PP_W-1:0]  out_pp,
  output logic             out_last
);

  localparam int IDX_W = $clog2(N_PP);
  localparam int ENT_W = EXP_W + PP_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_PP - 1);

  state_t state, state_n;

  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [EXP_W-1:0] exp_max_r;
  logic [EXP_W-1:0] run_max;
  logic [EXP_W-1:0] max_n;
  logic             seen_nz;
  logic             mag_nz;
  logic             accept;
  logic             fire;
  logic [ENT_W-1:0] rd_data;

  assign accept = in_valid && (state == FILL);
  assign fire   = out_ready && (state == DRAIN);
  assign mag_nz = |in_pp[PP_W-2:PP_MAG_LO];

  // Zero-magnitude beats never contribute to the max
  always_comb begin
    max_n = run_max;
    if (mag_nz && (!seen_nz || (in_exp > run_max))) begin
      max_n = in_exp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && (wr_idx == LAST)) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && (rd_idx == LAST)) begin
          state_n = FILL;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      exp_max_r <= '0;
      run_max   <= '0;
      seen_nz   <= 1'b0;
    end else begin
      if (accept) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_idx == LAST) begin
          exp_max_r <= max_n;
          run_max   <= '0;
          seen_nz   <= 1'b0;
        end else begin
          run_max <= max_n;
          seen_nz <= seen_nz | mag_nz;
        end
      end
      if (fire) begin
        rd_idx <= rd_idx + 1'b1;
        if (rd_idx == LAST) begin
          run_max <= '0;
          seen_nz <= 1'b0;
        end
      end
    end
  end

  pp_group_buf #(
    .N     (N_PP),
    .W     (ENT_W),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_idx),
    .wdata ({in_exp, in_pp}),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  assign {out_exp, out_pp} = rd_data;
  assign out_exp_max = exp_max_r;
  assign out_last    = (state == DRAIN) && (rd_idx == LAST);

endmodule
